acc_requant_packer: RTL and testbench



---
 rtl/acc_requant_packer.sv | 166 ++++++++++++++++
 tb/tb_acc_requant_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_requant_packer.sv
// acc_requant_packer: requantizes signed accumulator elements (shift, optional
// rounding, optional ReLU, saturation) and packs PACK_NUM activations into one
// output word. Pipeline is S1 (input register) -> ASM (lane assembly) -> OUT.
// Optional feature macro: REQUANT_ROUND_EN (round-half-up before the shift).
// Without it the shift is a pure truncating (floor) arithmetic shift.
module acc_requant_packer #(
   parameter int IN_WIDTH    = 15,
   parameter int SHIFT_WIDTH = 4,
   parameter int OUT_WIDTH   = 8,
   parameter int PACK_NUM    = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [IN_WIDTH-1:0]           i_data,
   input  logic [SHIFT_WIDTH-1:0]        i_shift_value,
   input  logic                          i_relu_en,
   input  logic                          i_last,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [PACK_NUM*OUT_WIDTH-1:0] o_data,
   output logic [PACK_NUM-1:0]           o_keep,
   output logic                          o_last
);

   // Intermediate width wide enough that data + rounding offset never overflows
   localparam int W = ((IN_WIDTH > (1 << SHIFT_WIDTH)) ? IN_WIDTH : (1 << SHIFT_WIDTH)) + 1;
   localparam int LANE_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);
   localparam logic signed [W-1:0] SAT_MAX = W'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [W-1:0] SAT_MIN = W'(-(2 ** (OUT_WIDTH - 1)));

   logic                          r_s1Valid;
   logic signed [IN_WIDTH-1:0]    r_s1Data;
   logic [SHIFT_WIDTH-1:0]        r_s1Shift;
   logic                          r_s1Relu;
   logic                          r_s1Last;

   logic [PACK_NUM*OUT_WIDTH-1:0] r_asm;
   logic [LANE_W-1:0]             r_lane;

   logic                          r_oValid;
   logic [PACK_NUM*OUT_WIDTH-1:0] r_oData;
   logic [PACK_NUM-1:0]           r_oKeep;
   logic                          r_oLast;

   logic signed [W-1:0]           w_ext;
   logic signed [W-1:0]           w_rnd;
   logic signed [W-1:0]           w_sum;
   logic signed [W-1:0]           w_shr;
   logic signed [W-1:0]           w_relu;
   logic [OUT_WIDTH-1:0]          w_result;
   logic [PACK_NUM*OUT_WIDTH-1:0] w_mergedData;
   logic [PACK_NUM-1:0]           w_mergedKeep;
   logic                          w_complete;
   logic                          w_outFree;
   logic                          w_s1Advance;
   logic                          w_accept;

   // Handshake: a completing element needs OUT free, others always move on
   assign w_complete  = r_s1Last || (r_lane == LAST_LANE);
   assign w_outFree   = !r_oValid || i_ready;
   assign w_s1Advance = r_s1Valid && (!w_complete || w_outFree);
   assign o_ready     = !r_s1Valid || w_s1Advance;
   assign w_accept    = i_valid && o_ready;

   assign o_valid = r_oValid;
   assign o_data  = r_oData;
   assign o_keep  = r_oKeep;
   assign o_last  = r_oLast;

   // Rounding offset: half an LSB of the shifted result when enabled
   always_comb begin
      w_rnd = '0;
`ifdef REQUANT_ROUND_EN
      if (r_s1Shift != '0) begin
         w_rnd = W'(1) << (r_s1Shift - 1'b1);
      end
`endif
   end

   assign w_ext  = W'(r_s1Data);
   assign w_sum  = w_ext + w_rnd;
   assign w_shr  = w_sum >>> r_s1Shift;
   assign w_relu = (r_s1Relu && w_shr[W-1]) ? '0 : w_shr;

   // Saturate the shifted value into the signed activation range
   always_comb begin
      if (w_relu > SAT_MAX) begin
         w_result = SAT_MAX[OUT_WIDTH-1:0];
      end else if (w_relu < SAT_MIN) begin
         w_result = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
         w_result = w_relu[OUT_WIDTH-1:0];
      end
   end

   // Build the outgoing word: filled ASM lanes, current S1 lane, zeros above
   always_comb begin
      w_mergedData = '0;
      w_mergedKeep = '0;
      for (int i = 0; i < PACK_NUM; i++) begin
         if (i < int'(r_lane)) begin
            w_mergedData[i*OUT_WIDTH +: OUT_WIDTH] = r_asm[i*OUT_WIDTH +: OUT_WIDTH];
            w_mergedKeep[i] = 1'b1;
         end else if (i == int'(r_lane)) begin
            w_mergedData[i*OUT_WIDTH +: OUT_WIDTH] = w_result;
            w_mergedKeep[i] = 1'b1;
         end
      end
   end

   // Stage 1: capture an accepted element with its per-element controls
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Data  <= '0;
         r_s1Shift <= '0;
         r_s1Relu  <= 1'b0;
         r_s1Last  <= 1'b0;
      end else if (w_accept) begin
         r_s1Valid <= 1'b1;
         r_s1Data  <= i_data;
         r_s1Shift <= i_shift_value;
         r_s1Relu  <= i_relu_en;
         r_s1Last  <= i_last;
      end else if (w_s1Advance) begin
         r_s1Valid <= 1'b0;
      end
   end

   // Assembly: park non-completing lanes, clear once a word is handed to OUT
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_asm  <= '0;
         r_lane <= '0;
      end else if (w_s1Advance) begin
         if (w_complete) begin
            r_asm  <= '0;
            r_lane <= '0;
         end else begin
            r_asm[r_lane*OUT_WIDTH +: OUT_WIDTH] <= w_result;
            r_lane <= r_lane + 1'b1;
         end
      end
   end

   // Output register: reload on completion (even while draining), hold otherwise
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_oValid <= 1'b0;
         r_oData  <= '0;
         r_oKeep  <= '0;
         r_oLast  <= 1'b0;
      end else if (w_s1Advance && w_complete) begin
         r_oValid <= 1'b1;
         r_oData  <= w_mergedData;
         r_oKeep  <= w_mergedKeep;
         r_oLast  <= r_s1Last;
      end else if (i_ready) begin
         r_oValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_requant_packer.sv
// tb_acc_requant_packer: directed vectors for acc_requant_packer with
// hand-computed expected words. Follows REQUANT_ROUND_EN like the design.
module tb_acc_requant_packer;

   localparam int IN_WIDTH    = 15;
   localparam int SHIFT_WIDTH = 4;
   localparam int OUT_WIDTH   = 8;
   localparam int PACK_NUM    = 4;

   logic                          i_clk = 1'b0;
   logic                          i_rst_n = 1'b0;
   logic                          i_valid = 1'b0;
   logic                          o_ready;
   logic [IN_WIDTH-1:0]           i_data = '0;
   logic [SHIFT_WIDTH-1:0]        i_shift_value = '0;
   logic                          i_relu_en = 1'b0;
   logic                          i_last = 1'b0;
   logic                          o_valid;
   logic                          i_ready = 1'b1;
   logic [PACK_NUM*OUT_WIDTH-1:0] o_data;
   logic [PACK_NUM-1:0]           o_keep;
   logic                          o_last;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   logic [31:0] qData[$];
   logic [3:0]  qKeep[$];
   logic        qLast[$];
   int          qCycle[$];

   int arVal[8]   = '{302, -6, 2000, -2000, -2000, -16384, 16383, 100};
   int arShift[8] = '{2, 2, 0, 0, 0, 15, 15, 1};
   int arRelu[8]  = '{0, 0, 0, 0, 1, 0, 0, 1};
`ifdef REQUANT_ROUND_EN
   int arExp[8]   = '{32'h4C, 32'hFF, 32'h7F, 32'h80, 32'h00, 32'h00, 32'h00, 32'h32};
`else
   int arExp[8]   = '{32'h4B, 32'hFE, 32'h7F, 32'h80, 32'h00, 32'hFF, 32'h00, 32'h32};
`endif

   acc_requant_packer #(
      .IN_WIDTH(IN_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .PACK_NUM(PACK_NUM)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_data(i_data),
      .i_shift_value(i_shift_value),
      .i_relu_en(i_relu_en),
      .i_last(i_last),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_data(o_data),
      .o_keep(o_keep),
      .o_last(o_last)
   );

   // Free-running clock
   always #5 i_clk = ~i_clk;

   // Cycle counter used to timestamp delivered words
   always @(posedge i_clk) cycleCount <= cycleCount + 1;

   // Capture every word the downstream side accepts
   always @(negedge i_clk) begin
      if (i_rst_n && o_valid && i_ready) begin
         qData.push_back(o_data);
         qKeep.push_back(o_keep);
         qLast.push_back(o_last);
         qCycle.push_back(cycleCount);
      end
   end

   // Hard stop in case something hangs outside a bounded wait
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int value, input int shift, input logic relu, input logic last);
      bit accepted;
      int waitCycles;
      accepted = 1'b0;
      waitCycles = 0;
      i_valid = 1'b1;
      i_data = IN_WIDTH'(value);
      i_shift_value = SHIFT_WIDTH'(shift);
      i_relu_en = relu;
      i_last = last;
      while (!accepted && waitCycles < 100) begin
         @(negedge i_clk);
         accepted = o_ready;
         @(posedge i_clk);
         #1;
         waitCycles++;
      end
      i_valid = 1'b0;
      i_last = 1'b0;
      i_relu_en = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitWords(input int n);
      int w;
      w = 0;
      while (qData.size() < n && w < 200) begin
         @(posedge i_clk);
         #1;
         w++;
      end
      checkOutput("word_count", 64'(qData.size()), 64'(n));
   endtask

   task automatic checkWord(input string tag, input logic [31:0] expData, input logic [3:0] expKeep,
                            input logic expLast, output int cyc);
      cyc = 0;
      if (qData.size() == 0) begin
         checkOutput({tag, "_missing"}, 64'd0, 64'd1);
      end else begin
         checkOutput({tag, "_data"}, 64'(qData.pop_front()), 64'(expData));
         checkOutput({tag, "_keep"}, 64'(qKeep.pop_front()), 64'(expKeep));
         checkOutput({tag, "_last"}, 64'(qLast.pop_front()), 64'(expLast));
         cyc = qCycle.pop_front();
      end
   endtask

   task automatic clearQueues();
      qData.delete();
      qKeep.delete();
      qLast.delete();
      qCycle.delete();
   endtask

   // Directed scenario sequence
   initial begin
      int acc;
      int rel;
      int c0;
      int c1;
      int c2;

      $display("[TB] reset");
      i_rst_n = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("rst_o_valid", 64'(o_valid), 64'd0);
      checkOutput("rst_o_data", 64'(o_data), 64'd0);
      checkOutput("rst_o_keep", 64'(o_keep), 64'd0);
      checkOutput("rst_o_last", 64'(o_last), 64'd0);
      checkOutput("rst_o_ready", 64'(o_ready), 64'd1);
      @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      checkOutput("post_rst_o_ready", 64'(o_ready), 64'd1);

      $display("[TB] packing");
      clearQueues();
      applyStimulus(1, 0, 1'b0, 1'b0);
      applyStimulus(2, 0, 1'b0, 1'b0);
      applyStimulus(3, 0, 1'b0, 1'b0);
      applyStimulus(4, 0, 1'b0, 1'b0);
      checkOutput("pack_lat_n1_valid", 64'(o_valid), 64'd0);
      @(posedge i_clk);
      #1;
      checkOutput("pack_lat_n2_valid", 64'(o_valid), 64'd1);
      checkOutput("pack_lat_n2_data", 64'(o_data), 64'h04030201);
      checkOutput("pack_lat_n2_keep", 64'(o_keep), 64'hF);
      checkOutput("pack_lat_n2_last", 64'(o_last), 64'd0);
      waitWords(1);
      checkWord("pack", 32'h04030201, 4'b1111, 1'b0, c0);

      $display("[TB] arithmetic");
      clearQueues();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(arVal[i], arShift[i], arRelu[i][0], 1'b1);
      end
      waitWords(8);
      for (int i = 0; i < 8; i++) begin
         checkWord($sformatf("arith%0d", i), 32'(arExp[i]), 4'b0001, 1'b1, c0);
      end

      $display("[TB] partial flush");
      clearQueues();
      applyStimulus(5, 0, 1'b0, 1'b0);
      applyStimulus(6, 0, 1'b0, 1'b1);
      applyStimulus(7, 0, 1'b0, 1'b0);
      applyStimulus(8, 0, 1'b0, 1'b0);
      applyStimulus(9, 0, 1'b0, 1'b0);
      applyStimulus(10, 0, 1'b0, 1'b0);
      waitWords(2);
      checkWord("flush", 32'h00000605, 4'b0011, 1'b1, c0);
      checkWord("after_flush", 32'h0A090807, 4'b1111, 1'b0, c0);

      $display("[TB] backpressure");
      repeat (3) @(posedge i_clk);
      #1;
      clearQueues();
      i_ready = 1'b0;
      i_shift_value = '0;
      i_relu_en = 1'b0;
      i_last = 1'b0;
      i_valid = 1'b1;
      acc = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         i_data = IN_WIDTH'(16 + acc);
         @(negedge i_clk);
         if (o_ready) acc++;
         @(posedge i_clk);
         #1;
      end
      checkOutput("bp_accepted", 64'(acc), 64'd8);
      checkOutput("bp_o_ready_low", 64'(o_ready), 64'd0);
      checkOutput("bp_o_valid", 64'(o_valid), 64'd1);
      checkOutput("bp_o_data", 64'(o_data), 64'h13121110);
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("bp_stable_data", 64'(o_data), 64'h13121110);
      checkOutput("bp_stable_keep", 64'(o_keep), 64'hF);
      i_ready = 1'b1;
      rel = 0;
      while (acc < 12 && rel < 50) begin
         i_data = IN_WIDTH'(16 + acc);
         @(negedge i_clk);
         if (o_ready) acc++;
         @(posedge i_clk);
         #1;
         rel++;
      end
      i_valid = 1'b0;
      checkOutput("bp_release_cycles", 64'(rel), 64'd4);
      waitWords(3);
      checkWord("bp_word0", 32'h13121110, 4'b1111, 1'b0, c0);
      checkWord("bp_word1", 32'h17161514, 4'b1111, 1'b0, c1);
      checkWord("bp_word2", 32'h1B1A1918, 4'b1111, 1'b0, c2);
      checkOutput("bp_no_gap", 64'(c1 - c0), 64'd1);

      $display("[TB] reset mid-word");
      clearQueues();
      i_ready = 1'b0;
      applyStimulus(32'h55, 0, 1'b0, 1'b0);
      applyStimulus(32'h66, 0, 1'b0, 1'b0);
      #2 i_rst_n = 1'b0;
      #1;
      checkOutput("midrst_o_valid", 64'(o_valid), 64'd0);
      checkOutput("midrst_o_data", 64'(o_data), 64'd0);
      checkOutput("midrst_o_keep", 64'(o_keep), 64'd0);
      checkOutput("midrst_o_last", 64'(o_last), 64'd0);
      checkOutput("midrst_o_ready", 64'(o_ready), 64'd1);
      @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      applyStimulus(32'h21, 0, 1'b0, 1'b0);
      applyStimulus(32'h22, 0, 1'b0, 1'b0);
      applyStimulus(32'h23, 0, 1'b0, 1'b0);
      applyStimulus(32'h24, 0, 1'b0, 1'b0);
      waitWords(1);
      checkWord("rst_new", 32'h24232221, 4'b1111, 1'b0, c0);
      repeat (5) @(posedge i_clk);
      #1;
      checkOutput("no_extra_words", 64'(qData.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
